// File: rtl/rot_pkg.sv
// Shared definitions for the rotating accumulator: default widths,
// state encoding and the pi/6 angle coefficients in Q2.16.
package rot_pkg;

  localparam int W_DEF    = 16;
  localparam int CW_DEF   = 18;
  localparam int FRAC_DEF = 16;
  localparam int NW_DEF   = 8;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_MUL  = 2'd1;
  localparam logic [1:0] ST_ACC  = 2'd2;

  typedef enum logic [1:0] {
    IDLE = ST_IDLE,
    MUL  = ST_MUL,
    ACC  = ST_ACC
  } state_e;

  localparam int COS_PI6_Q16 = 56756;
  localparam int SIN_PI6_Q16 = 32768;

endpackage

// File: rtl/cplx_mult_stage.sv
// Complex multiply stage: four signed W x CW multipliers whose full-width
// products are registered when en is high and held otherwise.
module cplx_mult_stage #(
  parameter int W  = 16,
  parameter int CW = 18
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   en,
  input  logic signed [W-1:0]    a_re,
  input  logic signed [W-1:0]    a_im,
  input  logic signed [CW-1:0]   c_cos,
  input  logic signed [CW-1:0]   c_sin,
  output logic signed [W+CW-1:0] p_rc,
  output logic signed [W+CW-1:0] p_is,
  output logic signed [W+CW-1:0] p_rs,
  output logic signed [W+CW-1:0] p_ic
);

  localparam int PW = W + CW;

  logic signed [PW-1:0] re_x_s, im_x_s, cos_x_s, sin_x_s;
  logic signed [PW-1:0] p_rc_d, p_is_d, p_rs_d, p_ic_d;
  logic signed [PW-1:0] p_rc_q, p_is_q, p_rs_q, p_ic_q;

  // Sign-extend operands to product width and form the four products.
  always_comb begin
    re_x_s  = PW'(a_re);
    im_x_s  = PW'(a_im);
    cos_x_s = PW'(c_cos);
    sin_x_s = PW'(c_sin);
    if (en) begin
      p_rc_d = re_x_s * cos_x_s;
      p_is_d = im_x_s * sin_x_s;
      p_rs_d = re_x_s * sin_x_s;
      p_ic_d = im_x_s * cos_x_s;
    end else begin
      p_rc_d = p_rc_q;
      p_is_d = p_is_q;
      p_rs_d = p_rs_q;
      p_ic_d = p_ic_q;
    end
  end

  // Product registers, cleared on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p_rc_q <= '0;
      p_is_q <= '0;
      p_rs_q <= '0;
      p_ic_q <= '0;
    end else begin
      p_rc_q <= p_rc_d;
      p_is_q <= p_is_d;
      p_rs_q <= p_rs_d;
      p_ic_q <= p_ic_d;
    end
  end

  assign p_rc = p_rc_q;
  assign p_is = p_is_q;
  assign p_rs = p_rs_q;
  assign p_ic = p_ic_q;

endmodule

// File: rtl/rot_acc_seq.sv
// Complex rotating accumulator: rotates (q_re, q_im) n_steps times by the
// angle given as cos/sin fixed-point coefficients, two cycles per step.
// Optional build macro ROT_SAT_EN: saturate results instead of wrapping.
module rot_acc_seq
  import rot_pkg::*;
#(
  parameter int W    = W_DEF,
  parameter int CW   = CW_DEF,
  parameter int FRAC = FRAC_DEF,
  parameter int NW   = NW_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          ld,
  input  logic [W-1:0]  x_re,
  input  logic [W-1:0]  x_im,
  input  logic          start,
  input  logic [NW-1:0] n_steps,
  input  logic [CW-1:0] cos_c,
  input  logic [CW-1:0] sin_c,
  output logic          busy,
  output logic          done,
  output logic [W-1:0]  q_re,
  output logic [W-1:0]  q_im
);

  localparam int PW = W + CW;
  localparam logic [NW-1:0] CNT_ONE = {{(NW-1){1'b0}}, 1'b1};

  state_e               state_q, state_d;
  logic [CW-1:0]        cos_q, cos_d, sin_q, sin_d;
  logic [NW-1:0]        cnt_q, cnt_d;
  logic                 busy_q, busy_d, done_q, done_d;
  logic [W-1:0]         q_re_q, q_re_d, q_im_q, q_im_d;
  logic                 mul_en_s;
  logic signed [PW-1:0] p_rc_s, p_is_s, p_rs_s, p_ic_s;
  logic signed [PW-1:0] re_full_s, im_full_s;
  logic [W:0]           re_sum_s, im_sum_s;

  // Reduce a W+1-bit sum to W bits: saturate or keep the low bits.
  function automatic logic [W-1:0] reduce_w(input logic [W:0] s);
`ifdef ROT_SAT_EN
    if (s[W] != s[W-1]) begin
      reduce_w = s[W] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
    end else begin
      reduce_w = s[W-1:0];
    end
`else
    reduce_w = W'(s);
`endif
  endfunction

  cplx_mult_stage #(.W(W), .CW(CW)) u_mult (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (mul_en_s),
    .a_re  (q_re_q),
    .a_im  (q_im_q),
    .c_cos (cos_q),
    .c_sin (sin_q),
    .p_rc  (p_rc_s),
    .p_is  (p_is_s),
    .p_rs  (p_rs_s),
    .p_ic  (p_ic_s)
  );

  // Floor-scale the products and combine them; sums are kept in W+1 bits.
  always_comb begin
    re_full_s = (p_rc_s >>> FRAC) - (p_is_s >>> FRAC);
    im_full_s = (p_rs_s >>> FRAC) + (p_ic_s >>> FRAC);
    re_sum_s  = (W+1)'(re_full_s);
    im_sum_s  = (W+1)'(im_full_s);
  end

  // Sequencer: load/start handling in IDLE, multiply then accumulate per step.
  always_comb begin
    state_d  = state_q;
    cos_d    = cos_q;
    sin_d    = sin_q;
    cnt_d    = cnt_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    q_re_d   = q_re_q;
    q_im_d   = q_im_q;
    mul_en_s = 1'b0;
    case (state_q)
      IDLE: begin
        if (ld) begin
          q_re_d = x_re;
          q_im_d = x_im;
        end else if (start) begin
          if (n_steps == '0) begin
            done_d = 1'b1;
          end else begin
            cos_d   = cos_c;
            sin_d   = sin_c;
            cnt_d   = n_steps;
            busy_d  = 1'b1;
            state_d = MUL;
          end
        end else begin
          state_d = IDLE;
        end
      end
      MUL: begin
        mul_en_s = 1'b1;
        state_d  = ACC;
      end
      ACC: begin
        q_re_d = reduce_w(re_sum_s);
        q_im_d = reduce_w(im_sum_s);
        cnt_d  = cnt_q - CNT_ONE;
        if (cnt_q == CNT_ONE) begin
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = IDLE;
        end else begin
          state_d = MUL;
        end
      end
      default: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  // State, accumulator, coefficient and handshake registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cos_q   <= '0;
      sin_q   <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      q_re_q  <= '0;
      q_im_q  <= '0;
    end else begin
      state_q <= state_d;
      cos_q   <= cos_d;
      sin_q   <= sin_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      q_re_q  <= q_re_d;
      q_im_q  <= q_im_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign q_re = q_re_q;
  assign q_im = q_im_q;

endmodule

// File: tb/tb_rot_acc_seq.sv
// Testbench for rot_acc_seq: directed vector table, random runs against a
// step-by-step arithmetic reference, and handshake/abort corner cases.
module tb_rot_acc_seq;
  import rot_pkg::*;

  localparam int W = 16, CW = 18, FRAC = 16, NW = 8;

  logic          clk = 1'b0;
  logic          rst_n, ld, start, busy, done;
  logic [W-1:0]  x_re, x_im, q_re, q_im;
  logic [NW-1:0] n_steps;
  logic [CW-1:0] cos_c, sin_c;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    int xr; int xi; int n; int c; int s; int er; int ei;
  } vec_t;

  vec_t tbl[6];

  always #5 clk = ~clk;

  rot_acc_seq #(.W(W), .CW(CW), .FRAC(FRAC), .NW(NW)) dut (
    .clk(clk), .rst_n(rst_n), .ld(ld), .x_re(x_re), .x_im(x_im),
    .start(start), .n_steps(n_steps), .cos_c(cos_c), .sin_c(sin_c),
    .busy(busy), .done(done), .q_re(q_re), .q_im(q_im)
  );

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int qr();
    return int'($signed(q_re));
  endfunction

  function automatic int qi();
    return int'($signed(q_im));
  endfunction

  // Reduce an exact sum: first to W+1 bits, then saturate or wrap to W bits.
  function automatic int reduce_model(input longint v);
    logic [W:0]   t;
    logic [W-1:0] u;
    longint       s;
    t = v[W:0];
    s = longint'($signed(t));
    u = t[W-1:0];
`ifdef ROT_SAT_EN
    if (s > 32767) return 32767;
    else if (s < -32768) return -32768;
    else return int'(s);
`else
    return int'($signed(u));
`endif
  endfunction

  // Reference rotation: n steps of floor-scaled complex multiply.
  task automatic model_rot(input int re0, input int im0, input int c, input int s,
                           input int n, output int re, output int im);
    longint r, i, nr, ni;
    r = re0;
    i = im0;
    for (int k = 0; k < n; k++) begin
      nr = ((r * c) >>> FRAC) - ((i * s) >>> FRAC);
      ni = ((r * s) >>> FRAC) + ((i * c) >>> FRAC);
      r = reduce_model(nr);
      i = reduce_model(ni);
    end
    re = int'(r);
    im = int'(i);
  endtask

  task automatic load(input int xr, input int xi);
    @(negedge clk);
    ld = 1'b1; x_re = xr[W-1:0]; x_im = xi[W-1:0];
    @(negedge clk);
    ld = 1'b0;
  endtask

  // Pulse start for one edge, then count edges until done (bounded).
  task automatic run_seq(input int n, input int c, input int s,
                         output int lat, output int busy0);
    @(negedge clk);
    start = 1'b1; n_steps = n[NW-1:0]; cos_c = c[CW-1:0]; sin_c = s[CW-1:0];
    @(negedge clk);
    start = 1'b0;
    busy0 = int'(busy);
    lat = 0;
    while (!done && lat < 2 * n + 8) begin
      @(negedge clk);
      lat++;
    end
  endtask

  // Common end-of-run checks: latency, busy drop, q value, one-cycle done.
  task automatic finish_checks(input string tag, input int n, input int lat,
                               input int busy0, input int er, input int ei);
    check({tag, "_lat"}, lat, 2 * n);
    check({tag, "_busy0"}, busy0, (n != 0) ? 1 : 0);
    check({tag, "_busy_end"}, int'(busy), 0);
    check({tag, "_re"}, qr(), er);
    check({tag, "_im"}, qi(), ei);
    @(negedge clk);
    check({tag, "_done_pulse"}, int'(done), 0);
  endtask

  initial begin
    int lat, b0, er, ei, xr, xi, c, s, n;

    tbl[0] = '{xr: 16384,  xi: 0,     n: 1, c: COS_PI6_Q16, s: SIN_PI6_Q16, er: 14189, ei: 8192};
`ifdef ROT_SAT_EN
    tbl[1] = '{xr: 30000,  xi: 30000, n: 1, c: 65536, s: 65536, er: 0, ei: 32767};
`else
    tbl[1] = '{xr: 30000,  xi: 30000, n: 1, c: 65536, s: 65536, er: 0, ei: -5536};
`endif
    tbl[2] = '{xr: 1000,   xi: -2000, n: 3, c: 65536, s: 0, er: 1000, ei: -2000};
    tbl[3] = '{xr: -16384, xi: 100,   n: 2, c: 0, s: 65536, er: 16384, ei: -100};
    tbl[4] = '{xr: -3,     xi: 0,     n: 1, c: 32768, s: 0, er: -2, ei: 0};
    tbl[5] = '{xr: 5,      xi: 7,     n: 1, c: -65536, s: 0, er: -5, ei: -7};

    rst_n = 1'b0; ld = 1'b0; start = 1'b0;
    x_re = '0; x_im = '0; n_steps = '0; cos_c = '0; sin_c = '0;
    #12;
    check("rst_q_re", qr(), 0);
    check("rst_q_im", qi(), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed vector table.
    for (int v = 0; v < 6; v++) begin
      load(tbl[v].xr, tbl[v].xi);
      check($sformatf("v%0d_load_re", v), qr(), tbl[v].xr);
      check($sformatf("v%0d_load_im", v), qi(), tbl[v].xi);
      run_seq(tbl[v].n, tbl[v].c, tbl[v].s, lat, b0);
      finish_checks($sformatf("v%0d", v), tbl[v].n, lat, b0, tbl[v].er, tbl[v].ei);
    end

    // Twelve pi/6 steps return close to the start point.
    load(16384, 0);
    run_seq(12, COS_PI6_Q16, SIN_PI6_Q16, lat, b0);
    model_rot(16384, 0, COS_PI6_Q16, SIN_PI6_Q16, 12, er, ei);
    check("twelve_tol_re", int'(qr() - 16384 <= 12 && qr() - 16384 >= -12), 1);
    check("twelve_tol_im", int'(qi() <= 12 && qi() >= -12), 1);
    finish_checks("twelve", 12, lat, b0, er, ei);

    // N = 0: immediate done, never busy, q unchanged.
    load(-1234, 4321);
    run_seq(0, COS_PI6_Q16, SIN_PI6_Q16, lat, b0);
    finish_checks("nzero", 0, lat, b0, -1234, 4321);

    // ld and start together: load only.
    @(negedge clk);
    ld = 1'b1; start = 1'b1; x_re = 16'd777; x_im = 16'd888; n_steps = 8'd1;
    @(negedge clk);
    ld = 1'b0; start = 1'b0;
    check("ldst_re", qr(), 777);
    check("ldst_im", qi(), 888);
    check("ldst_busy", int'(busy), 0);
    check("ldst_done", int'(done), 0);
    @(negedge clk);
    check("ldst_done2", int'(done), 0);
    check("ldst_busy2", int'(busy), 0);

    // Commands while busy are ignored.
    load(1234, -567);
    @(negedge clk);
    start = 1'b1; n_steps = 8'd3;
    cos_c = COS_PI6_Q16[CW-1:0]; sin_c = SIN_PI6_Q16[CW-1:0];
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    ld = 1'b1; start = 1'b1; x_re = 16'd7; x_im = 16'd7; n_steps = 8'd1;
    cos_c = '0; sin_c = '0;
    @(negedge clk);
    @(negedge clk);
    ld = 1'b0; start = 1'b0;
    lat = 3;
    while (!done && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    model_rot(1234, -567, COS_PI6_Q16, SIN_PI6_Q16, 3, er, ei);
    finish_checks("ignore", 3, lat, 1, er, ei);

    // Reset mid-sequence aborts immediately.
    load(1000, 2000);
    @(negedge clk);
    start = 1'b1; n_steps = 8'd5;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("abort_re", qr(), 0);
    check("abort_im", qi(), 0);
    check("abort_busy", int'(busy), 0);
    check("abort_done", int'(done), 0);
    @(negedge clk);
    rst_n = 1'b1;
    load(16384, 0);
    run_seq(1, COS_PI6_Q16, SIN_PI6_Q16, lat, b0);
    finish_checks("after_abort", 1, lat, b0, 14189, 8192);

    // Randomized runs against the reference model.
    for (int r = 0; r < 20; r++) begin
      xr = int'($urandom_range(0, 65535)) - 32768;
      xi = int'($urandom_range(0, 65535)) - 32768;
      c  = int'($urandom_range(0, 262143)) - 131072;
      s  = int'($urandom_range(0, 262143)) - 131072;
      n  = int'($urandom_range(1, 5));
      load(xr, xi);
      run_seq(n, c, s, lat, b0);
      model_rot(xr, xi, c, s, n, er, ei);
      finish_checks($sformatf("rnd%0d", r), n, lat, b0, er, ei);
    end

    // Maximum step count.
    load(20000, -10000);
    run_seq(255, COS_PI6_Q16, SIN_PI6_Q16, lat, b0);
    model_rot(20000, -10000, COS_PI6_Q16, SIN_PI6_Q16, 255, er, ei);
    finish_checks("nmax", 255, lat, b0, er, ei);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/rot_acc_seq.md
Name: rot_acc_seq

Overview:
Parametrised complex rotating accumulator. It holds a complex value (q_re, q_im) and, on command, rotates it N times by a run-time angle given as fixed-point cos/sin coefficients. It uses a 2-cycle pipelined complex multiply per step and a start/busy/done handshake. It sits in the DSP datapath as the next-generation rotator: generic widths, programmable angle and step count, signed arithmetic, reset and handshake.

Parameters:
W, 16, data width of the re/im parts (two's complement)
CW, 18, coefficient width (two's complement)
FRAC, 16, fractional bits of the coefficients (Q(CW-FRAC).FRAC)
NW, 8, width of the step counter / n_steps

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
ld  in  1  load x_re/x_im into the accumulator (honoured only when idle)
x_re  in  W  load value, real part
x_im  in  W  load value, imaginary part
start  in  1  begin rotation sequence (honoured only when idle)
n_steps  in  NW  number of rotations, sampled on start
cos_c  in  CW  cos(angle)*2^FRAC, sampled on start
sin_c  in  CW  sin(angle)*2^FRAC, sampled on start
busy  out  1  sequence in progress
done  out  1  one-cycle pulse when the sequence completes
q_re  out  W  accumulator, real part
q_im  out  W  accumulator, imaginary part

Behaviour:
- Reset (async, rst_n=0): q_re=q_im=0, busy=0, done=0, state=IDLE, product and coefficient registers=0. Reset mid-sequence aborts it immediately. After release, the block is in IDLE.
- States: IDLE, MUL, ACC.
- IDLE with ld=1: q<=x at the next edge. ld has priority over start: with ld=1 and start=1 in the same cycle, the load happens and start is ignored.
- IDLE with start=1, ld=0, n_steps>0: latch cos_c, sin_c and n_steps; busy<=1; go to MUL.
- IDLE with start=1, ld=0, n_steps=0: done<=1 for one cycle, busy stays 0, q unchanged.
- MUL: register four signed full products (W+CW bits): q_re*cos, q_im*sin, q_re*sin, q_im*cos. Go to ACC.
- ACC:
  - each product is arithmetically shifted right by FRAC (truncation toward -inf);
  - re = (re*cos)>>FRAC - (im*sin)>>FRAC and im = (re*sin)>>FRAC + (im*cos)>>FRAC, each computed in W+1 bits;
  - the W+1-bit results are reduced to W bits (see Optional Feature) and written to q;
  - counter decrements. If it reaches 0: busy<=0, done<=1, go to IDLE. Otherwise go to MUL.
- Latency: start sampled at edge k gives step i result at edge k+2i. The final q, busy=0 and done=1 all appear at edge k+2N. done is high for exactly one cycle.
- While busy: ld, start and input changes are ignored. The latched coefficients are used for all steps.
- q is stable between updates and changes only at ACC edges or on a load.
- n_steps = 2^NW-1 is supported; no wrap of the counter.

Optional Feature:
ROT_SAT_EN
- Defined: W+1-bit sums outside the W-bit range saturate to +(2^(W-1)-1) or -2^(W-1).
- Undefined: sums wrap (the low W bits are kept).

Decomposition:
- Shared package rot_pkg holds:
  - defaults for W, CW, FRAC, NW;
  - state encoding constants (IDLE=2'd0, MUL=2'd1, ACC=2'd2);
  - angle constants COS_PI6_Q16=56756 and SIN_PI6_Q16=32768.
- One sub-module, cplx_mult_stage: four signed multipliers with a registered full-width product output, parameterised by W and CW.
- The FSM, counter, shift/sum and saturation stay in rot_acc_seq.

Test Plan:
- Single step: ld (16384,0); start with cos=56756, sin=32768, N=1 -> busy for 2 cycles, done pulse, q=(14189,8192) exactly.
- Twelve steps: ld (16384,0); start with π/6 coefficients, N=12 -> done at edge k+24, q within ±12 LSB of (16384,0).
- Boundary: start with N=0 -> done one cycle later, busy never high, q unchanged. ld and start in the same cycle -> load only, no done.
- Overflow: ld (30000,30000); cos=sin=65536, N=1 -> q_im=32767 with ROT_SAT_EN, -5536 without; q_re=0 in both cases.
- Ignored commands and abort:
  - start/ld pulsed while busy -> no effect on q, the step count or the done timing;
  - rst_n low mid-sequence -> q=0, busy=0, done=0 immediately;
  - a subsequent N=1 run works.
